// File: rtl/mux_select_arbiter.sv
// Round-robin scheduler sharing one 4:1 Mux between four requesters.
// Steers the Mux select lines, waits a settle window when the select
// actually changes, then issues a one-hot grant with a bounded tenure.
module mux_select_arbiter #(
    parameter int SETTLE_CYCLES = 3,
    parameter int MAX_HOLD      = 8,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] select,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MAX_HOLD - 1);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_select, w_select_nx;
    logic [3:0]       r_grant, w_grant_nx;
    logic             r_busy, w_busy_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_last, w_last_nx;

    logic [1:0]       w_winner;
    logic             w_any_req;
    logic             w_sel_req;

    // First requester found scanning upward from the one after the last served.
    function automatic logic [1:0] rr_pick(input logic [3:0] rq, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && rq[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_winner  = rr_pick(req, r_last);
    assign w_any_req = |req;
    assign w_sel_req = req[r_select];

    // State and output registers; reset parks the Mux on input 0 with req0 first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_select <= 2'd0;
            r_grant  <= 4'd0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_last   <= 2'd3;
        end else begin
            r_state  <= w_state_nx;
            r_select <= w_select_nx;
            r_grant  <= w_grant_nx;
            r_busy   <= w_busy_nx;
            r_cnt    <= w_cnt_nx;
            r_last   <= w_last_nx;
        end
    end

    // Next-state and next-output decode; select only moves on the IDLE->SETTLE step.
    always_comb begin
        w_state_nx  = r_state;
        w_select_nx = r_select;
        w_grant_nx  = r_grant;
        w_busy_nx   = r_busy;
        w_cnt_nx    = r_cnt;
        w_last_nx   = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_busy_nx = 1'b1;
                    w_cnt_nx  = '0;
                    if (w_winner != r_select) begin
                        // Mux must be re-steered: wait for its output to settle.
                        w_select_nx = w_winner;
                        w_state_nx  = ST_SETTLE;
                    end else begin
                        // Mux already points at the winner, grant straight away.
                        w_grant_nx = 4'b0001 << w_winner;
                        w_state_nx = ST_GRANT;
                    end
                end
            end
            ST_SETTLE: begin
                if (!w_sel_req) begin
                    // Requester gave up before the grant: abandon without granting.
                    w_last_nx  = r_select;
                    w_busy_nx  = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_grant_nx = 4'b0001 << r_select;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_GRANT;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_sel_req || (r_cnt == HOLD_LAST)) begin
                    w_grant_nx = 4'd0;
                    w_busy_nx  = 1'b0;
                    w_last_nx  = r_select;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = 4'd0;
                w_busy_nx  = 1'b0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign select = r_select;
    assign grant  = r_grant;
    assign busy   = r_busy;

endmodule
